// File: rtl/store_mb_pkg.sv
// Shared encoder definitions for the macroblock store path.
// Holds pixel depth, beat counts, derived bus widths and the FSM state type
// used by store_mb. The optional stall counter in store_mb is enabled by the
// macro STORE_MB_STALL_CNT_EN.
package store_mb_pkg;

  localparam int unsigned BIT_DEPTH    = 8;
  localparam int unsigned MB_BEATS     = 48;
  localparam int unsigned LUMA_BEATS   = 32;
  localparam int unsigned PIX_PER_BEAT = 8;

  localparam int unsigned Y_PIX  = 256;
  localparam int unsigned C_PIX  = 64;
  localparam int unsigned Y_W    = Y_PIX * BIT_DEPTH;
  localparam int unsigned C_W    = C_PIX * BIT_DEPTH;
  localparam int unsigned BEAT_W = PIX_PER_BEAT * BIT_DEPTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/store_mb_pack.sv
// Combinational beat selector for store_mb.
// Ports:
//   y, u, v : macroblock planes, pixel j at bits [(j+1)*BIT_DEPTH-1 : j*BIT_DEPTH]
//   beat    : beat index 0..47 (0..31 luma, 32..47 interleaved chroma)
//   data    : 8 pixels for that beat, first pixel in the MSBs
module store_mb_pack
  import store_mb_pkg::*;
(
  input  logic [Y_W-1:0]    y,
  input  logic [C_W-1:0]    u,
  input  logic [C_W-1:0]    v,
  input  logic [5:0]        beat,
  output logic [BEAT_W-1:0] data
);

  logic [BIT_DEPTH-1:0] y_pix [Y_PIX];
  logic [BIT_DEPTH-1:0] u_pix [C_PIX];
  logic [BIT_DEPTH-1:0] v_pix [C_PIX];

  always_comb begin
    for (int unsigned j = 0; j < Y_PIX; j++) begin
      y_pix[j] = y[j*BIT_DEPTH +: BIT_DEPTH];
    end
    for (int unsigned j = 0; j < C_PIX; j++) begin
      u_pix[j] = u[j*BIT_DEPTH +: BIT_DEPTH];
      v_pix[j] = v[j*BIT_DEPTH +: BIT_DEPTH];
    end
  end

  // Beat index bits address the pixel directly: luma pixel = {beat, k},
  // chroma pixel = {beat - 32, k} where the low 4 beat bits already give beat-32.
  always_comb begin
    data = '0;
    if (beat < 6'(LUMA_BEATS)) begin
      for (int unsigned k = 0; k < PIX_PER_BEAT; k++) begin
        data[BEAT_W-1-k*BIT_DEPTH -: BIT_DEPTH] = y_pix[{beat[4:0], 3'(k)}];
      end
    end else begin
      for (int unsigned k = 0; k < PIX_PER_BEAT/2; k++) begin
        data[BEAT_W-1-(2*k)*BIT_DEPTH   -: BIT_DEPTH] = u_pix[{beat[3:0], 2'(k)}];
        data[BEAT_W-1-(2*k+1)*BIT_DEPTH -: BIT_DEPTH] = v_pix[{beat[3:0], 2'(k)}];
      end
    end
  end

endmodule

// File: rtl/store_mb.sv
// Reconstructed-macroblock store: captures a 4:2:0 macroblock presented in
// parallel and streams it as 48 beats of 8 pixels over a valid/ready bus.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   store_start       : pulse, capture rec_* and begin sending (ignored while busy)
//   store_done        : one-cycle pulse after the last beat is accepted
//   busy              : high from capture until the last beat is accepted
//   rec_y_i/u_i/v_i   : luma 256 px, Cb 64 px, Cr 64 px, raster packed
//   pvalid_o/pready_i : beat handshake
//   pdata_o           : 8 pixels per beat, first pixel in the MSBs
//   stall_cnt_o       : saturating count of valid&&!ready cycles when
//                       STORE_MB_STALL_CNT_EN is defined, otherwise 0
module store_mb
  import store_mb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              store_start,
  output logic              store_done,
  output logic              busy,
  input  logic [Y_W-1:0]    rec_y_i,
  input  logic [C_W-1:0]    rec_u_i,
  input  logic [C_W-1:0]    rec_v_i,
  output logic              pvalid_o,
  input  logic              pready_i,
  output logic [BEAT_W-1:0] pdata_o,
  output logic [15:0]       stall_cnt_o
);

  state_t            state;
  logic [5:0]        beat;
  logic [Y_W-1:0]    y_buf;
  logic [C_W-1:0]    u_buf;
  logic [C_W-1:0]    v_buf;

  logic              handshake;
  logic              last_beat;
  logic              start_acc;

  logic [Y_W-1:0]    src_y;
  logic [C_W-1:0]    src_u;
  logic [C_W-1:0]    src_v;
  logic [5:0]        src_beat;
  logic [BEAT_W-1:0] packed_beat;

  assign handshake = pvalid_o && pready_i;
  assign last_beat = handshake && (beat == 6'(MB_BEATS - 1));
  assign start_acc = (state == ST_IDLE) && store_start;

  // pdata_o is registered, so the selector looks one beat ahead. On capture
  // it reads the live inputs so beat 0 is ready the cycle after store_start.
  always_comb begin
    if (start_acc) begin
      src_y    = rec_y_i;
      src_u    = rec_u_i;
      src_v    = rec_v_i;
      src_beat = '0;
    end else begin
      src_y    = y_buf;
      src_u    = u_buf;
      src_v    = v_buf;
      src_beat = beat + 6'd1;
    end
  end

  store_mb_pack u_pack (
    .y    (src_y),
    .u    (src_u),
    .v    (src_v),
    .beat (src_beat),
    .data (packed_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      beat       <= '0;
      y_buf      <= '0;
      u_buf      <= '0;
      v_buf      <= '0;
      pvalid_o   <= 1'b0;
      busy       <= 1'b0;
      store_done <= 1'b0;
      pdata_o    <= '0;
    end else begin
      store_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (store_start) begin
            y_buf    <= rec_y_i;
            u_buf    <= rec_u_i;
            v_buf    <= rec_v_i;
            beat     <= '0;
            pdata_o  <= packed_beat;
            pvalid_o <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (last_beat) begin
            beat       <= '0;
            pdata_o    <= '0;
            pvalid_o   <= 1'b0;
            busy       <= 1'b0;
            store_done <= 1'b1;
            state      <= ST_IDLE;
          end else if (handshake) begin
            beat    <= beat + 6'd1;
            pdata_o <= packed_beat;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STORE_MB_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cnt <= '0;
    end else if (pvalid_o && !pready_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_store_mb.sv
// Self-checking bench for store_mb: table vectors for the fixed ordering
// cases, hand sequences for backpressure/recapture/back-to-back/reset, and
// randomized macroblocks with random ready against a pixel-array model.
module tb_store_mb;

  logic          clk = 1'b0;
  logic          rst;
  logic          store_start;
  logic          store_done;
  logic          busy;
  logic [2047:0] rec_y_i;
  logic [511:0]  rec_u_i;
  logic [511:0]  rec_v_i;
  logic          pvalid_o;
  logic          pready_i;
  logic [63:0]   pdata_o;
  logic [15:0]   stall_cnt_o;

  store_mb dut (
    .clk         (clk),
    .rst         (rst),
    .store_start (store_start),
    .store_done  (store_done),
    .busy        (busy),
    .rec_y_i     (rec_y_i),
    .rec_u_i     (rec_u_i),
    .rec_v_i     (rec_v_i),
    .pvalid_o    (pvalid_o),
    .pready_i    (pready_i),
    .pdata_o     (pdata_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: the macroblock the DUT is expected to be sending.
  logic [7:0]  my_y [256];
  logic [7:0]  my_u [64];
  logic [7:0]  my_v [64];
  logic [63:0] got  [48];

  typedef struct {
    int          idx;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < 8; k++) begin
      if (n < 32) r = {r[55:0], my_y[8*n + k]};
      else if (k % 2 == 0) r = {r[55:0], my_u[4*(n-32) + k/2]};
      else r = {r[55:0], my_v[4*(n-32) + k/2]};
    end
    return r;
  endfunction

  task automatic drive_mb();
    for (int j = 0; j < 256; j++) rec_y_i[j*8 +: 8] = my_y[j];
    for (int j = 0; j < 64; j++) begin
      rec_u_i[j*8 +: 8] = my_u[j];
      rec_v_i[j*8 +: 8] = my_v[j];
    end
  endtask

  task automatic set_ramp();
    for (int j = 0; j < 256; j++) my_y[j] = 8'(j);
    for (int j = 0; j < 64; j++) begin
      my_u[j] = 8'(8'h80 + j);
      my_v[j] = 8'(8'hC0 + j);
    end
    drive_mb();
  endtask

  task automatic set_fill(input logic [7:0] val);
    for (int j = 0; j < 256; j++) my_y[j] = val;
    for (int j = 0; j < 64; j++) begin
      my_u[j] = val;
      my_v[j] = val;
    end
    drive_mb();
  endtask

  task automatic set_random();
    for (int j = 0; j < 256; j++) my_y[j] = 8'($urandom);
    for (int j = 0; j < 64; j++) begin
      my_u[j] = 8'($urandom);
      my_v[j] = 8'($urandom);
    end
    drive_mb();
  endtask

  // Called at a negedge while idle; returns at the negedge where beat 0 shows.
  task automatic start_mb(input string nm);
    store_start = 1'b1;
    @(negedge clk);
    store_start = 1'b0;
    check({nm, "_start_valid"}, 64'(pvalid_o), 64'd1);
    check({nm, "_start_busy"},  64'(busy),     64'd1);
  endtask

  // Consumes all 48 beats starting at the current negedge. mode 0: always
  // ready, 1: random ready, 2: three stall cycles at beat 5. pulse_at>=0
  // raises store_start for one cycle while that beat is presented.
  // Returns at the negedge of the store_done cycle.
  task automatic drain(input string nm, input int mode, input int pulse_at);
    int  beat   = 0;
    int  stalls = 0;
    int  held   = 0;
    int  cyc    = 0;
    bit  pulsed = 0;
    bit  rdy;
    while (beat < 48 && cyc < 4000) begin
      check({nm, "_valid"}, 64'(pvalid_o), 64'd1);
      check({nm, "_data"},  pdata_o, exp_beat(beat));
      check({nm, "_done_low"}, 64'(store_done), 64'd0);
      if (mode == 2 && beat == 5)
        check({nm, "_bp_hold"}, pdata_o, 64'h28292A2B2C2D2E2F);
      store_start = 1'b0;
      if (!pulsed && beat == pulse_at) begin
        store_start = 1'b1;
        pulsed = 1;
      end
      case (mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       if (beat == 5 && held < 3) begin rdy = 0; held++; end else rdy = 1;
        default: rdy = 1;
      endcase
      pready_i = rdy;
      if (!rdy) stalls++;
      else got[beat] = pdata_o;
      @(negedge clk);
      if (rdy) beat++;
      cyc++;
    end
    store_start = 1'b0;
    pready_i    = 1'b0;
    check({nm, "_beat_count"}, 64'(beat), 64'd48);
    check({nm, "_done"},       64'(store_done), 64'd1);
    check({nm, "_end_valid"},  64'(pvalid_o),   64'd0);
    check({nm, "_end_busy"},   64'(busy),       64'd0);
`ifdef STORE_MB_STALL_CNT_EN
    check({nm, "_stalls"}, 64'(stall_cnt_o), 64'(stalls));
`else
    check({nm, "_stalls"}, 64'(stall_cnt_o), 64'd0);
`endif
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0,  64'h0001020304050607};
    vecs[1] = '{1,  64'h08090A0B0C0D0E0F};
    vecs[2] = '{31, 64'hF8F9FAFBFCFDFEFF};
    vecs[3] = '{32, 64'h80C081C182C283C3};
    vecs[4] = '{47, 64'hBCFCBDFDBEFEBFFF};

    rst         = 1'b1;
    store_start = 1'b0;
    pready_i    = 1'b0;
    rec_y_i     = '0;
    rec_u_i     = '0;
    rec_v_i     = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(pvalid_o),  64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(store_done), 64'd0);
    check("rst_data",  pdata_o,        64'd0);
    check("rst_stall", 64'(stall_cnt_o), 64'd0);
    rst = 1'b0;

    // Ready while idle does nothing.
    pready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready_valid", 64'(pvalid_o), 64'd0);
      check("idle_ready_busy",  64'(busy),     64'd0);
    end
    pready_i = 1'b0;

    // Ordering with ramp data, then the fixed-value table.
    set_ramp();
    start_mb("ramp");
    drain("ramp", 0, -1);
    @(negedge clk);
    check("ramp_done_once", 64'(store_done), 64'd0);
    for (int i = 0; i < 5; i++)
      check($sformatf("table_beat%0d", vecs[i].idx), got[vecs[i].idx], vecs[i].exp);

    // Backpressure at beat 5.
    start_mb("bp");
    drain("bp", 2, -1);
    @(negedge clk);
    check("bp_done_once", 64'(store_done), 64'd0);

    // Inputs change after capture; store_start again while busy at beat 10.
    set_ramp();
    start_mb("recap");
    for (int j = 0; j < 256; j++) rec_y_i[j*8 +: 8] = 8'($urandom);
    drain("recap", 1, 10);
    repeat (4) begin
      @(negedge clk);
      check("recap_single_done", 64'(store_done), 64'd0);
      check("recap_idle", 64'(busy), 64'd0);
    end

    // Back-to-back: next MB started in the store_done cycle.
    set_ramp();
    start_mb("b2b_a");
    drain("b2b_a", 0, -1);
    set_fill(8'h55);
    start_mb("b2b_b");
    check("b2b_first_beat", pdata_o, 64'h5555555555555555);
    check("b2b_done_low",   64'(store_done), 64'd0);
    drain("b2b_b", 1, -1);
    @(negedge clk);

    // Reset mid-transfer at beat 20.
    set_random();
    start_mb("mid");
    pready_i = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_beat20", pdata_o, exp_beat(20));
    rst      = 1'b1;
    pready_i = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(pvalid_o),   64'd0);
    check("mid_rst_busy",  64'(busy),       64'd0);
    check("mid_rst_done",  64'(store_done), 64'd0);
    check("mid_rst_data",  pdata_o,         64'd0);
    check("mid_rst_stall", 64'(stall_cnt_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    set_random();
    start_mb("after_rst");
    drain("after_rst", 1, -1);
    @(negedge clk);

    // Randomized macroblocks with random backpressure.
    for (int t = 0; t < 6; t++) begin
      set_random();
      start_mb($sformatf("rnd%0d", t));
      drain($sformatf("rnd%0d", t), 1, (t % 2 == 0) ? int'($urandom_range(0, 47)) : -1);
      if (t % 3 != 2) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
